ram_write_arbiter: RTL

//  Shares the single write port of the cell-state RAM between three requesters:
//  - the cell-update engine (sim), highest priority
//  - the user brush (draw) path, buffered in a small FIFO
//  - an internal clear sequencer that zeroes the whole field on request

---
 rtl/game_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/ram_write_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and defaults for the cell-field datapath.
//  - CELLS:        cell count of the default 640x480 field
//  - arb_state_t:  write-arbiter FSM state
//  - wr_grant_t:   which source owns the RAM write port this cycle
//  - cells_of():   cell count for an arbitrary field size
package game_pkg;

  localparam int unsigned DEFAULT_COLUMNS = 640;
  localparam int unsigned DEFAULT_ROWS    = 480;
  localparam int unsigned CELLS           = DEFAULT_COLUMNS * DEFAULT_ROWS;

  typedef enum logic [0:0] {IDLE, CLEAR} arb_state_t;

  typedef enum logic [1:0] {GNT_NONE, GNT_SIM, GNT_CLEAR, GNT_DRAW} wr_grant_t;

  function automatic int unsigned cells_of(input int unsigned cols, input int unsigned rows);
    return cols * rows;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational read port (head always visible).
// Ports:
//  clk_i, reset_i    clock, synchronous active-high reset (empties the FIFO)
//  push_i, wdata_i   write an entry (ignored when full unless popping too)
//  pop_i, rdata_o    remove the head entry; rdata_o shows the head
//  full_o, empty_o   occupancy flags derived from the stored count
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full_o    = (r_count == CNT_W'(DEPTH));
  assign empty_o   = (r_count == '0);
  assign rdata_o   = r_mem[r_rd_ptr];
  // A push into a full FIFO is only safe when the head leaves in the same cycle.
  assign w_do_push = push_i & (~full_o | pop_i);
  assign w_do_pop  = pop_i & ~empty_o;

  // Storage: no reset needed, validity is tracked by the count.
  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata_i;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ram_write_arbiter.sv
// Shares the cell-state RAM write port between the sim engine, a clear
// sequencer and the buffered brush path. Priority: sim > clear > draw.
// Ports:
//  clk_i, reset_i                      clock, synchronous active-high reset
//  sim_wr_en/addr/data_i               sim writes, always granted
//  sim_active_i                        holds off draw drain while a generation runs
//  draw_valid_i/addr/data_i, draw_ready_o   brush entries into the FIFO
//  clear_start_i, clear_busy_o, clear_done_o full-field clear control/status
//  draw_overflow_o                     sticky: brush offered while FIFO full
//  ram_wr_en/addr/data_o               registered RAM write port
module ram_write_arbiter
  import game_pkg::*;
#(
  parameter int unsigned ACTIVE_COLUMNS  = DEFAULT_COLUMNS,
  parameter int unsigned ACTIVE_ROWS     = DEFAULT_ROWS,
  parameter int unsigned ADDR_WIDTH      = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
  parameter int unsigned DATA_WIDTH      = 2,
  parameter int unsigned DRAW_FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  sim_wr_en_i,
  input  logic [ADDR_WIDTH-1:0] sim_wr_addr_i,
  input  logic [DATA_WIDTH-1:0] sim_wr_data_i,
  input  logic                  sim_active_i,
  input  logic                  draw_valid_i,
  output logic                  draw_ready_o,
  input  logic [ADDR_WIDTH-1:0] draw_addr_i,
  input  logic [DATA_WIDTH-1:0] draw_data_i,
  input  logic                  clear_start_i,
  output logic                  clear_busy_o,
  output logic                  clear_done_o,
  output logic                  draw_overflow_o,
  output logic                  ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wr_data_o
);

  localparam int unsigned            FIELD_CELLS = cells_of(ACTIVE_COLUMNS, ACTIVE_ROWS);
  localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR   = ADDR_WIDTH'(FIELD_CELLS - 1);
  localparam int unsigned            FIFO_W      = ADDR_WIDTH + DATA_WIDTH;

  arb_state_t r_state;
  arb_state_t w_next_state;
  wr_grant_t  w_grant;

  logic [ADDR_WIDTH-1:0] r_clear_addr;
  logic                  w_clear_last;

  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [FIFO_W-1:0]     w_fifo_wdata;
  logic [FIFO_W-1:0]     w_fifo_rdata;
  logic [ADDR_WIDTH-1:0] w_draw_addr;
  logic [DATA_WIDTH-1:0] w_draw_data;
  logic                  w_draw_in_range;

  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_clear_done;
  logic                  r_overflow;

  // Brush FIFO: entry = {addr, data}.
  assign w_push       = draw_valid_i & ~w_fifo_full;
  assign w_pop        = (w_grant == GNT_DRAW);
  assign w_fifo_wdata = {draw_addr_i, draw_data_i};

  sync_fifo #(
    .DEPTH (DRAW_FIFO_DEPTH),
    .WIDTH (FIFO_W)
  ) u_draw_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i (w_fifo_wdata),
    .rdata_o (w_fifo_rdata),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  assign w_draw_addr     = w_fifo_rdata[FIFO_W-1:DATA_WIDTH];
  assign w_draw_data     = w_fifo_rdata[DATA_WIDTH-1:0];
  // Out-of-field brush entries are popped but never written.
  assign w_draw_in_range = (w_draw_addr <= LAST_ADDR);
  assign w_clear_last    = (r_clear_addr == LAST_ADDR);

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // Grant selection and next state.
  always_comb begin
    w_grant      = GNT_NONE;
    w_next_state = r_state;
    if (sim_wr_en_i) begin
      w_grant = GNT_SIM;
    end else if (r_state == CLEAR) begin
      w_grant = GNT_CLEAR;
    end else if (!w_fifo_empty && !sim_active_i) begin
      w_grant = GNT_DRAW;
    end
    case (r_state)
      IDLE:    if (clear_start_i) w_next_state = CLEAR;
      CLEAR:   if (w_grant == GNT_CLEAR && w_clear_last) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Clear address counter; holds while sim owns the port so no cell is skipped.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_clear_addr <= '0;
    end else if (r_state == IDLE && clear_start_i) begin
      r_clear_addr <= '0;
    end else if (w_grant == GNT_CLEAR) begin
      r_clear_addr <= w_clear_last ? '0 : r_clear_addr + ADDR_WIDTH'(1);
    end
  end

  // Registered write port; address/data hold when nothing is written.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_clear_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_wr_en      <= 1'b0;
      r_clear_done <= 1'b0;
      case (w_grant)
        GNT_SIM: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= sim_wr_addr_i;
          r_wr_data <= sim_wr_data_i;
        end
        GNT_CLEAR: begin
          r_wr_en      <= 1'b1;
          r_wr_addr    <= r_clear_addr;
          r_wr_data    <= '0;
          r_clear_done <= w_clear_last;
        end
        GNT_DRAW: begin
          if (w_draw_in_range) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= w_draw_addr;
            r_wr_data <= w_draw_data;
          end
        end
        default: ;
      endcase
      if (draw_valid_i && w_fifo_full) r_overflow <= 1'b1;
    end
  end

  assign draw_ready_o    = ~w_fifo_full;
  assign clear_busy_o    = (r_state == CLEAR);
  assign clear_done_o    = r_clear_done;
  assign draw_overflow_o = r_overflow;
  assign ram_wr_en_o     = r_wr_en;
  assign ram_wr_addr_o   = r_wr_addr;
  assign ram_wr_data_o   = r_wr_data;

endmodule
